// File: rtl/bitonic_sort_pipe.sv
// Pipelined bitonic sorting network for muon candidates, keyed on pt.
// Registers after every REG_EVERY compare-exchange layers; valid/ready back-pressure.
package bitonic_sorter_pkg;
    typedef struct packed {
        logic [7:0] pt;
        logic [5:0] eta;
        logic [5:0] phi;
        logic [1:0] qual;
    } muon_t;
endpackage

module bitonic_sort_pipe
    import bitonic_sorter_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 8,
    parameter int DIR       = 1,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  muon_t [0:WIDTH-1]     m,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output muon_t [0:OUT_WIDTH-1] q,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  busy
);

    localparam int LW = $clog2(WIDTH);
    localparam int L  = LW * (LW + 1) / 2;
    localparam int S  = (L + REG_EVERY - 1) / REG_EVERY;

    typedef muon_t [0:WIDTH-1] frame_t;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("WIDTH must be a power of 2 and at least 2");
    end
    if (OUT_WIDTH < 1 || OUT_WIDTH > WIDTH) begin : g_bad_out_width
        $error("OUT_WIDTH must be in 1..WIDTH");
    end
    if (REG_EVERY < 1) begin : g_bad_reg_every
        $error("REG_EVERY must be at least 1");
    end

    // Layer idx walks (k, j) in the usual order: k = 2..WIDTH, j = k/2..1.
    function automatic int layer_k(input int idx);
        int n;
        int r;
        n = 0;
        r = WIDTH;
        for (int k = 2; k <= WIDTH; k = k * 2) begin
            for (int j = k / 2; j > 0; j = j / 2) begin
                if (n == idx) r = k;
                n = n + 1;
            end
        end
        return r;
    endfunction

    function automatic int layer_j(input int idx);
        int n;
        int r;
        n = 0;
        r = 1;
        for (int k = 2; k <= WIDTH; k = k * 2) begin
            for (int j = k / 2; j > 0; j = j / 2) begin
                if (n == idx) r = j;
                n = n + 1;
            end
        end
        return r;
    endfunction

    // DIR=1 mirrors every block direction, so the final merge descends.
    function automatic frame_t cex(input frame_t f, input int k, input int j);
        frame_t r;
        int     p;
        logic   asc;
        logic   sw;
        r = f;
        for (int i = 0; i < WIDTH; i++) begin
            p = i ^ j;
            if (p > i) begin
                asc = (((i & k) == 0) != (DIR != 0));
                sw  = asc ? (f[i].pt > f[p].pt) : (f[i].pt < f[p].pt);
                if (sw) begin
                    r[i] = f[p];
                    r[p] = f[i];
                end
            end
        end
        return r;
    endfunction

    frame_t           data_q [S];
    frame_t           data_d [S];
    logic [TAG_W-1:0] tag_q  [S];
    logic [TAG_W-1:0] tag_d  [S];
    logic             vld_q  [S];
    logic             vld_d  [S];
    logic             stall;

    assign stall    = vld_q[S-1] & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        data_d[0] = m;
        tag_d[0]  = in_tag;
        vld_d[0]  = in_valid;
        for (int s = 1; s < S; s++) begin
            data_d[s] = data_q[s-1];
            tag_d[s]  = tag_q[s-1];
            vld_d[s]  = vld_q[s-1];
        end
        for (int l = 0; l < L; l++) begin
            data_d[l / REG_EVERY] = cex(data_d[l / REG_EVERY],
                                        layer_k(l), layer_j(l));
        end
    end

    // The last stage keeps only the lanes that leave the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < S; s++) begin
                data_q[s] <= '0;
                tag_q[s]  <= '0;
                vld_q[s]  <= 1'b0;
            end
        end else if (!stall) begin
            for (int s = 0; s < S; s++) begin
                vld_q[s] <= vld_d[s];
                tag_q[s] <= tag_d[s];
                for (int i = 0; i < WIDTH; i++) begin
                    if (s < S - 1 || i < OUT_WIDTH) begin
                        data_q[s][i] <= data_d[s][i];
                    end
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < S; s++) begin
            busy = busy | vld_q[s];
        end
    end

    assign out_valid = vld_q[S-1];
    assign out_tag   = tag_q[S-1];
    assign q         = data_q[S-1][0:OUT_WIDTH-1];

endmodule
